// File: rtl/ddr_burst_reader.sv
// Burst read sequencer for a single-port RAM with 1-cycle read latency.
// Optional performance counters are enabled by defining DDR_RD_PERF_EN.
module ddr_burst_reader #(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_SIZE-1:0]  cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_SIZE-1:0]  ram_addra,
    input  logic [DATA_WIDTH-1:0] ram_douta,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
`ifdef DDR_RD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [15:0]           perf_burst_cnt
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for a command, cmd_ready high
    // S_ISSUE | issuing reads as FIFO credit allows
    // S_DRAIN | all reads issued, waiting for the last beat to be accepted
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [ADDR_SIZE-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_issue_cnt;
    logic                   r_inflight;
    logic                   r_inflight_last;

    logic [DATA_WIDTH-1:0]  r_fifo_data [FIFO_DEPTH];
    logic                   r_fifo_last [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    logic [CW-1:0]          w_credit_used;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_hs;
    logic                   w_issue_final;

    // A read is only launched when its returning word is guaranteed a FIFO slot.
    assign w_credit_used = r_count + CW'(r_inflight);
    assign w_issue       = (r_state == S_ISSUE) && (w_credit_used < CW'(FIFO_DEPTH));
    assign w_issue_final = (r_issue_cnt == r_len);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_push        = r_inflight;
    assign w_pop         = m_valid && m_ready;
    assign w_last_hs     = w_pop && m_last;

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next_state = S_ISSUE;
            S_ISSUE: if (w_issue && w_issue_final) w_next_state = S_DRAIN;
            S_DRAIN: if (w_last_hs) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        ram_ena   = w_issue;
    end

    assign ram_wea   = 1'b0;
    assign ram_addra = r_addr;

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_addr          <= '0;
            r_len           <= '0;
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= cmd_addr;
                r_len       <= cmd_len;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_SIZE'(1);
                r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_final;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ram_douta;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_valid = (r_count != '0);
    assign m_data  = r_fifo_data[r_rd_ptr];
    assign m_last  = r_fifo_last[r_rd_ptr];

`ifdef DDR_RD_PERF_EN
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            perf_stall_cnt <= '0;
            perf_burst_cnt <= '0;
        end else begin
            if (m_valid && !m_ready && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (w_last_hs && (perf_burst_cnt != '1)) begin
                perf_burst_cnt <= perf_burst_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_burst_reader.sv
// Randomized scoreboard bench for ddr_burst_reader; expected addresses and beats
// are derived from each command, and a negedge monitor compares what the DUT emits.
module tb_ddr_burst_reader;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int LW = 12;

    logic          s_clk = 1'b0;
    logic          s_rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_douta = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
`ifdef DDR_RD_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [15:0]   perf_burst_cnt;
`endif

    ddr_burst_reader #(
        .ADDR_SIZE(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_douta(ram_douta),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
`ifdef DDR_RD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_burst_cnt(perf_burst_cnt)
`endif
    );

    always #5 s_clk = ~s_clk;

    // RAM model: mem[i] = i, registered read.
    always @(posedge s_clk) begin
        if (ram_ena) ram_douta <= DW'(ram_addra);
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic [AW-1:0] q_addr [$];
    beat_t         q_beat [$];
    int            errors = 0;
    int            checks = 0;
    int            occ = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the test

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge s_clk);
            #1;
            if (rdy_mode == 0) m_ready = 1'b1;
            else if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: occ = reads issued minus words accepted (outstanding + buffered).
    initial begin
        beat_t b;
        logic [AW-1:0] a;
        forever begin
            @(negedge s_clk);
            if (s_rst) begin
                occ = 0;
            end else begin
                if (ram_ena) begin
                    check("credit_limit", 64'(occ < 4), 64'd1);
                    if (q_addr.size() == 0) begin
                        check("unexpected_read", 64'(ram_ena), 64'd0);
                    end else begin
                        a = q_addr.pop_front();
                        check("ram_addra", 64'(ram_addra), 64'(a));
                    end
                end
                if (m_valid && m_ready) begin
                    if (q_beat.size() == 0) begin
                        check("unexpected_beat", 64'(m_valid), 64'd0);
                    end else begin
                        b = q_beat.pop_front();
                        check("m_data", m_data, b.d);
                        check("m_last", 64'(m_last), 64'(b.l));
                    end
                end
                occ = occ + int'(ram_ena) - int'(m_valid && m_ready);
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, output int waited);
        bit ok;
        logic [AW-1:0] ad;
        beat_t b;
        @(posedge s_clk);
        #1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        waited    = 0;
        ok        = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge s_clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) check("cmd_accept_timeout", 64'(ok), 64'd1);
        if (ok) begin
            for (int i = 0; i <= int'(l); i++) begin
                ad = a + AW'(i);
                q_addr.push_back(ad);
                b.d = DW'(ad);
                b.l = (i == int'(l));
                q_beat.push_back(b);
            end
        end
        @(posedge s_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge s_clk);
            if (q_beat.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_done"}, 64'(ok), 64'd1);
        check({name, "_addr_left"}, 64'(q_addr.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;
        bit seen;
        logic [AW-1:0] ra;

        repeat (3) @(posedge s_clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        s_rst = 1'b0;

        // Reset in the middle of a stalled burst.
        rdy_mode = 2;
        m_ready  = 1'b0;
        send_cmd(16'h0010, 12'd7, w);
        repeat (4) @(posedge s_clk);
        #2;
        s_rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_ram_ena", 64'(ram_ena), 64'd0);
        check("mid_rst_ram_addra", 64'(ram_addra), 64'd0);
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_m_data", m_data, 64'd0);
        check("mid_rst_m_last", 64'(m_last), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("ram_wea", 64'(ram_wea), 64'd0);
        q_addr.delete();
        q_beat.delete();
        @(posedge s_clk);
        #1;
        s_rst = 1'b0;
        @(negedge s_clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_m_valid", 64'(m_valid), 64'd0);

        // Streaming at full rate.
        rdy_mode = 0;
        send_cmd(16'h0000, 12'd15, w);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge s_clk);
        end
        check("stream_start", 64'(seen), 64'd1);
        n = 0;
        while (m_valid && n < 40) begin
            n++;
            @(negedge s_clk);
        end
        check("stream_beats", 64'(n), 64'd16);
        wait_done("stream");

        // Random back-pressure.
        rdy_mode = 1;
        send_cmd(16'h0020, 12'd9, w);
        wait_done("bp");
        for (int k = 0; k < 8; k++) begin
            ra = AW'($urandom);
            send_cmd(ra, LW'($urandom_range(0, 20)), w);
            wait_done("rand");
        end

        // Address wrap.
        send_cmd(16'hFFFE, 12'd3, w);
        wait_done("wrap");

        // Single beat, then a command presented while busy.
        rdy_mode = 0;
        send_cmd(16'h0005, 12'd0, w);
        check("busy_after_accept", 64'(busy), 64'd1);
        check("cmd_ready_while_busy", 64'(cmd_ready), 64'd0);
        send_cmd(16'h0040, 12'd2, w);
        check("second_cmd_waited", 64'(w > 0), 64'd1);
        wait_done("single");

`ifdef DDR_RD_PERF_EN
        @(posedge s_clk);
        #1;
        s_rst = 1'b1;
        @(posedge s_clk);
        #1;
        s_rst = 1'b0;
        rdy_mode = 2;
        m_ready  = 1'b0;
        send_cmd(16'h0100, 12'd7, w);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge s_clk);
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("perf_start", 64'(seen), 64'd1);
        repeat (5) @(posedge s_clk);
        #1;
        m_ready = 1'b1;
        wait_done("perf");
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'd5);
        check("perf_burst_cnt", 64'(perf_burst_cnt), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
